icache: RTL and testbench

//  Direct-mapped, read-only instruction cache between the instruction fetcher and
//  the memory controller's fetcher port. Hits return an instruction one cycle after

---
 rtl/icache_if.sv | 29 ++
 rtl/icache.sv | 119 +++++++++++
 tb/tb_icache.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/icache_if.sv
// icache_if: fetcher-side and memory-controller-side signals of the instruction cache.
//   Fetcher side : in_if_req, in_if_addr -> cache; out_if_ready, out_if_valid, out_if_inst <- cache
//   Memory side  : out_mem_ena, out_mem_addr <- cache; in_mem_ok, in_mem_data -> cache
// Handshake: a request is taken on a clock edge where in_if_req and out_if_ready are both
// high (and ena is high, no rollback). out_if_valid is a one-cycle pulse per accepted request
// that produces data; there is no backpressure on the return path. On the memory side
// out_mem_ena is a one-cycle request, answered later by a one-cycle in_mem_ok pulse.
// modport master: the cache itself. modport slave: the fetcher/memory-controller environment.
interface icache_if;
    logic        in_if_req;
    logic [31:0] in_if_addr;
    logic        out_if_ready;
    logic        out_if_valid;
    logic [31:0] out_if_inst;
    logic        out_mem_ena;
    logic [31:0] out_mem_addr;
    logic        in_mem_ok;
    logic [31:0] in_mem_data;

    modport master (
        input  in_if_req, in_if_addr, in_mem_ok, in_mem_data,
        output out_if_ready, out_if_valid, out_if_inst, out_mem_ena, out_mem_addr
    );

    modport slave (
        output in_if_req, in_if_addr, in_mem_ok, in_mem_data,
        input  out_if_ready, out_if_valid, out_if_inst, out_mem_ena, out_mem_addr
    );
endinterface

// File: rtl/icache.sv
// icache: direct-mapped, read-only instruction cache, one 32-bit word per line.
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   ena             global enable, low holds state
//   in_rollback     misbranch flush, aborts any outstanding miss
//   bus             icache_if.master (fetcher request/return, memory fetch request/response)
//   dbg_state_o     current FSM state (IDLE=0, REQ=1, WAIT=2)
// Hits return data the cycle after acceptance; misses issue one fetch, fill the line and
// return the fetched word the cycle after in_mem_ok.
module icache #(
    parameter int INDEX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        in_rollback,
    icache_if.master    bus,
    output logic [1:0]  dbg_state_o
);
    localparam int LINES    = 2 ** INDEX_BITS;
    localparam int TAG_BITS = 32 - INDEX_BITS - 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [LINES-1:0]      line_valid_q;
    logic [TAG_BITS-1:0]   line_tag_q  [LINES];
    logic [31:0]           line_data_q [LINES];
    logic [31:2]           req_addr_q;
    logic                  if_valid_q;
    logic [31:0]           if_inst_q;

    logic [INDEX_BITS-1:0] lk_idx;
    logic [TAG_BITS-1:0]   lk_tag;
    logic                  lk_hit;
    logic                  accept;
    logic [INDEX_BITS-1:0] fill_idx;
    logic [TAG_BITS-1:0]   fill_tag;
    logic                  fill_en;
    logic                  unused_addr_bits;

    // Byte offset within the word is irrelevant to a word-granular cache.
    assign unused_addr_bits = ^bus.in_if_addr[1:0];

    assign lk_idx = bus.in_if_addr[INDEX_BITS+1:2];
    assign lk_tag = bus.in_if_addr[31:INDEX_BITS+2];
    assign lk_hit = line_valid_q[lk_idx] && (line_tag_q[lk_idx] == lk_tag);
    assign accept = !in_rollback && ena && (state_q == S_IDLE) && bus.in_if_req;

    assign fill_idx = req_addr_q[INDEX_BITS+1:2];
    assign fill_tag = req_addr_q[31:INDEX_BITS+2];
    // A response coinciding with rollback still fills: the data is correct, only the
    // return to the fetcher is suppressed.
    assign fill_en  = (state_q == S_WAIT) && bus.in_mem_ok && (in_rollback || ena);

    always_comb begin
        state_d = state_q;
        if (in_rollback) begin
            state_d = S_IDLE;
        end else if (ena) begin
            case (state_q)
                S_IDLE:  if (bus.in_if_req && !lk_hit) state_d = S_REQ;
                S_REQ:   state_d = S_WAIT;
                S_WAIT:  if (bus.in_mem_ok) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            line_valid_q <= '0;
            req_addr_q   <= '0;
            if_valid_q   <= 1'b0;
            if_inst_q    <= '0;
        end else begin
            state_q <= state_d;
            if (fill_en) begin
                line_valid_q[fill_idx] <= 1'b1;
            end
            if (in_rollback) begin
                if_valid_q <= 1'b0;
            end else if (ena) begin
                if_valid_q <= 1'b0;
                if (accept) begin
                    req_addr_q <= bus.in_if_addr[31:2];
                    if (lk_hit) begin
                        if_valid_q <= 1'b1;
                        if_inst_q  <= line_data_q[lk_idx];
                    end
                end else if (fill_en) begin
                    if_valid_q <= 1'b1;
                    if_inst_q  <= bus.in_mem_data;
                end
            end else begin
                // Holding with ena low must not stretch a return pulse.
                if_valid_q <= 1'b0;
            end
        end
    end

    // Tag and data storage carry no reset; the valid bits gate their use.
    always_ff @(posedge clk) begin
        if (!rst && fill_en) begin
            line_tag_q[fill_idx]  <= fill_tag;
            line_data_q[fill_idx] <= bus.in_mem_data;
        end
    end

    assign bus.out_if_ready = (state_q == S_IDLE);
    assign bus.out_mem_ena  = (state_q == S_REQ);
    assign bus.out_mem_addr = {req_addr_q, 2'b00};
    assign bus.out_if_valid = if_valid_q;
    assign bus.out_if_inst  = if_inst_q;
    assign dbg_state_o      = state_q;
endmodule

// File: tb/tb_icache.sv
module tb_icache;
  logic        clk;
  logic        rst;
  logic        ena;
  logic        in_rollback;
  logic [1:0]  dbg_state;
  icache_if    bus ();

  int n_checks = 0;
  int n_fails  = 0;

  logic [31:0] exp_q[$];      // expected out_if_inst values, in order
  logic [31:0] mem_exp_q[$];  // expected out_mem_addr values, in order

  // reference model for the random phase
  logic        mdl_valid [64];
  logic [23:0] mdl_tag   [64];
  logic [31:0] mdl_data  [64];

  icache #(.INDEX_BITS(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .in_rollback (in_rollback),
    .bus         (bus.master),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_if_valid) begin
        if (exp_q.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
        else check("if_inst", bus.out_if_inst, exp_q.pop_front());
      end
      if (bus.out_mem_ena && ena) begin
        if (mem_exp_q.size() == 0) check("unexpected_mem_ena", 32'd1, 32'd0);
        else check("mem_addr", bus.out_mem_addr, mem_exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [31:0] addr);
    bus.in_if_req  = 1'b1;
    bus.in_if_addr = addr;
    tick();
    bus.in_if_req  = 1'b0;
  endtask

  task automatic mem_resp(input logic [31:0] data, input logic rb);
    bus.in_mem_ok   = 1'b1;
    bus.in_mem_data = data;
    in_rollback     = rb;
    tick();
    bus.in_mem_ok   = 1'b0;
    in_rollback     = 1'b0;
  endtask

  task automatic do_hit(input logic [31:0] addr, input logic [31:0] data);
    exp_q.push_back(data);
    do_req(addr);
  endtask

  task automatic do_miss(input logic [31:0] addr, input logic [31:0] data);
    exp_q.push_back(data);
    mem_exp_q.push_back({addr[31:2], 2'b00});
    do_req(addr);   // now REQ
    tick();         // now WAIT
    mem_resp(data, 1'b0);
    tick();         // return pulse observed in the previous cycle
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_exp_q"}, exp_q.size(), 0);
    check({tag, "_mem_q"}, mem_exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},    {31'd0, bus.out_if_ready}, 32'd1);
    check({tag, "_valid"},    {31'd0, bus.out_if_valid}, 32'd0);
    check({tag, "_inst"},     bus.out_if_inst, 32'd0);
    check({tag, "_mem_ena"},  {31'd0, bus.out_mem_ena}, 32'd0);
    check({tag, "_mem_addr"}, bus.out_mem_addr, 32'd0);
    check({tag, "_state"},    {30'd0, dbg_state}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; in_rollback = 1'b0;
    bus.in_if_req = 1'b0; bus.in_if_addr = '0;
    bus.in_mem_ok = 1'b0; bus.in_mem_data = '0;
    repeat (3) tick();
    rst = 1'b0;
    check_reset_outputs("reset");

    // cold miss then hits, including back-to-back hits
    do_miss(32'h0000_1000, 32'h0050_0093);
    do_hit(32'h0000_1000, 32'h0050_0093);
    do_hit(32'h0000_1002, 32'h0050_0093);  // low address bits ignored
    tick();
    check_drained("hit");

    // conflict on index 0
    do_miss(32'h0000_1100, 32'hDEAD_BEEF);
    do_miss(32'h0000_1000, 32'h0050_0093);
    do_hit(32'h0000_1000, 32'h0050_0093);
    tick();
    check_drained("conflict");

    // rollback while waiting; late response ignored
    mem_exp_q.push_back(32'h0000_2000);
    do_req(32'h0000_2000);
    tick();
    check("wait_state", {30'd0, dbg_state}, 32'd2);
    in_rollback = 1'b1;
    tick();
    in_rollback = 1'b0;
    check("rb_ready", {31'd0, bus.out_if_ready}, 32'd1);
    mem_resp(32'h1111_1111, 1'b0);
    tick();
    check("rb_idle_after_late_ok", {30'd0, dbg_state}, 32'd0);
    do_miss(32'h0000_2000, 32'h1234_5678);
    check_drained("rollback");

    // rollback coincident with the response: fill without return
    mem_exp_q.push_back(32'h0000_3000);
    do_req(32'h0000_3000);
    tick();
    mem_resp(32'h0BAD_F00D, 1'b1);
    tick();
    do_hit(32'h0000_3000, 32'h0BAD_F00D);
    tick();
    check_drained("rb_ok");

    // ena low while in REQ holds the request; single transfer afterwards
    exp_q.push_back(32'hCAFE_0001);
    mem_exp_q.push_back(32'h0000_4000);
    do_req(32'h0000_4000);
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_mem_ena", {31'd0, bus.out_mem_ena}, 32'd1);
      check("hold_state", {30'd0, dbg_state}, 32'd1);
    end
    ena = 1'b1;
    tick();
    check("reenable_mem_ena", {31'd0, bus.out_mem_ena}, 32'd0);
    mem_resp(32'hCAFE_0001, 1'b0);
    tick();
    check_drained("ena");

    // reset in WAIT drops the fill and invalidates all lines
    mem_exp_q.push_back(32'h0000_5000);
    do_req(32'h0000_5000);
    tick();
    rst = 1'b1;
    bus.in_mem_ok = 1'b1; bus.in_mem_data = 32'h5555_5555;
    tick();
    rst = 1'b0;
    bus.in_mem_ok = 1'b0;
    check_reset_outputs("mid_rst");
    do_miss(32'h0000_1000, 32'h0050_0093);  // previously cached line must miss
    check_drained("mid_rst");

    // random hits/misses against a small model, starting from a clean cache
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 64; i++) mdl_valid[i] = 1'b0;
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      logic [5:0]  ix;
      logic [23:0] tg;
      ix = 6'($urandom_range(0, 3));
      tg = 24'($urandom_range(0, 2));
      a  = {tg, ix, 2'($urandom_range(0, 3))};
      if (mdl_valid[ix] && mdl_tag[ix] == tg) begin
        do_hit(a, mdl_data[ix]);
      end else begin
        mdl_valid[ix] = 1'b1;
        mdl_tag[ix]   = tg;
        mdl_data[ix]  = $urandom;
        do_miss(a, mdl_data[ix]);
      end
    end
    tick();
    check_drained("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
